// File: rtl/uart_bus_master.sv
// UART-driven debug bus initiator: parses 'W'/'R' command frames from the RX byte stream,
// issues one bus word transfer and returns '+', read data, '?' or '!' on the TX stream.
module uart_bus_master #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [31:0]           o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_wr_valid,
    input  logic                  i_wr_ready,
    output logic [2:0]            o_wr_width,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_rd_valid,
    output logic                  o_rd_ready,
    output logic                  o_busy
);

    // state  | meaning
    // IDLE   | waiting for a command byte
    // ADDR   | collecting 4 address bytes, LSB first
    // DATA   | collecting 4 write-data bytes, LSB first
    // BUS_WR | write request on the bus, timeout running
    // BUS_RD | read request on the bus, timeout running
    // RESP   | shifting reply bytes out, LSB first
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_BUS_WR, S_BUS_RD, S_RESP
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                  r_state, w_next;
    logic                    r_is_wr;
    logic [1:0]              r_byte_cnt;
    logic [TW-1:0]           r_to_cnt;
    logic [DATA_WIDTH-1:0]   r_resp;
    logic [2:0]              r_tx_cnt;
    logic [31:0]             r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    w_rx_fire, w_tx_fire, w_to_term, w_cmd_ok;

    assign o_rx_ready = !i_rst && (r_state == S_IDLE || r_state == S_ADDR || r_state == S_DATA);
    assign o_tx_valid = (r_state == S_RESP);
    assign o_tx_data  = r_resp[7:0];
    assign o_wr_valid = (r_state == S_BUS_WR);
    assign o_wr_width = o_wr_valid ? 3'd4 : 3'd0;
    assign o_rd_ready = (r_state == S_BUS_RD);
    assign o_busy     = (r_state != S_IDLE);
    assign o_addr     = r_addr;
    assign o_data     = r_data;

    assign w_rx_fire = i_rx_valid && o_rx_ready;
    assign w_tx_fire = o_tx_valid && i_tx_ready;
    assign w_to_term = (r_to_cnt == TW'(TIMEOUT - 1));
    assign w_cmd_ok  = (i_rx_data == 8'h57) || (i_rx_data == 8'h52);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_rx_fire) w_next = w_cmd_ok ? S_ADDR : S_RESP;
            S_ADDR:   if (w_rx_fire && r_byte_cnt == 2'd3) w_next = r_is_wr ? S_DATA : S_BUS_RD;
            S_DATA:   if (w_rx_fire && r_byte_cnt == 2'd3) w_next = S_BUS_WR;
            S_BUS_WR: if (i_wr_ready || w_to_term) w_next = S_RESP;
            S_BUS_RD: if (i_rd_valid || w_to_term) w_next = S_RESP;
            S_RESP:   if (w_tx_fire && r_tx_cnt == 3'd1) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_is_wr    <= 1'b0;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
            r_resp     <= '0;
            r_tx_cnt   <= '0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            if (r_state != w_next && (w_next == S_ADDR || w_next == S_DATA))
                r_byte_cnt <= '0;
            else if (w_rx_fire && (r_state == S_ADDR || r_state == S_DATA))
                r_byte_cnt <= r_byte_cnt + 2'd1;

            // saturating so a stuck bus can never wrap the counter back into range
            if (r_state != w_next && (w_next == S_BUS_WR || w_next == S_BUS_RD))
                r_to_cnt <= '0;
            else if ((r_state == S_BUS_WR || r_state == S_BUS_RD) && r_to_cnt != TW'(TIMEOUT))
                r_to_cnt <= r_to_cnt + TW'(1);

            case (r_state)
                S_IDLE: if (w_rx_fire) begin
                    r_is_wr <= (i_rx_data == 8'h57);
                    if (!w_cmd_ok) begin
                        r_resp   <= DATA_WIDTH'(8'h3F);
                        r_tx_cnt <= 3'd1;
                    end
                end
                S_ADDR: if (w_rx_fire) r_addr[{r_byte_cnt, 3'b000} +: 8] <= i_rx_data;
                S_DATA: if (w_rx_fire) r_data[{r_byte_cnt, 3'b000} +: 8] <= i_rx_data;
                S_BUS_WR: begin
                    if (i_wr_ready) begin
                        r_resp   <= DATA_WIDTH'(8'h2B);
                        r_tx_cnt <= 3'd1;
                    end else if (w_to_term) begin
                        r_resp   <= DATA_WIDTH'(8'h21);
                        r_tx_cnt <= 3'd1;
                    end
                end
                S_BUS_RD: begin
                    if (i_rd_valid) begin
                        r_resp   <= i_data;
                        r_tx_cnt <= 3'd4;
                    end else if (w_to_term) begin
                        r_resp   <= DATA_WIDTH'(8'h21);
                        r_tx_cnt <= 3'd1;
                    end
                end
                S_RESP: if (w_tx_fire) begin
                    r_resp   <= r_resp >> 8;
                    r_tx_cnt <= r_tx_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: write, read with TX stall, bad command,
// bus timeout, mid-frame reset and RX back-pressure.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_width;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uart_bus_master #(.DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_addr(addr), .o_data(wdata), .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
        .o_wr_width(wr_width), .i_data(rdata), .i_rd_valid(rd_valid),
        .o_rd_ready(rd_ready), .o_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // entered and left on a falling edge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin @(negedge clk); n++; end
        chk("rx_accept", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input string tag);
        int n = 0;
        while (!tx_valid && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
        chk(tag, 32'(tx_data), 32'(exp));
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        send_byte(c);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (c == 8'h57) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
        chk({tag, "_addr"},     addr,          32'd0);
        chk({tag, "_data"},     wdata,         32'd0);
        chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
        chk({tag, "_wr_width"}, 32'(wr_width), 32'd0);
        chk({tag, "_rd_ready"}, 32'(rd_ready), 32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        wr_ready = 1'b0; rdata = 32'h0; rd_valid = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rx_ready", 32'(rx_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // write frame, ready on the third cycle of o_wr_valid
        send_frame(8'h57, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("wr_valid", 32'(wr_valid), 32'd1);
        chk("wr_addr", addr, 32'h0000_0010);
        chk("wr_data", wdata, 32'hDEAD_BEEF);
        chk("wr_width", 32'(wr_width), 32'd4);
        chk("wr_rd_ready", 32'(rd_ready), 32'd0);
        chk("wr_rx_ready", 32'(rx_ready), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        chk("wr_valid_hold", 32'(wr_valid), 32'd1);
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        chk("wr_valid_drop", 32'(wr_valid), 32'd0);
        recv_byte(8'h2B, "wr_reply");
        chk("wr_done_busy", 32'(busy), 32'd0);

        // read frame with RX back-pressure and a 5-cycle TX stall
        send_frame(8'h52, 32'h0000_0010, 32'h0);
        chk("rd_ready", 32'(rd_ready), 32'd1);
        chk("rd_wr_valid", 32'(wr_valid), 32'd0);
        rx_data = 8'h99; rx_valid = 1'b1;
        chk("bp_busrd_rx_ready", 32'(rx_ready), 32'd0);
        repeat (2) @(negedge clk);
        rdata = 32'h1234_5678; rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        chk("bp_resp_rx_ready", 32'(rx_ready), 32'd0);
        recv_byte(8'h78, "rd_b0");
        for (int i = 0; i < 5; i++) begin
            chk("stall_tx_data", 32'(tx_data), 32'h56);
            chk("stall_tx_valid", 32'(tx_valid), 32'd1);
            @(negedge clk);
        end
        recv_byte(8'h56, "rd_b1");
        recv_byte(8'h34, "rd_b2");
        chk("bp_resp_rx_ready2", 32'(rx_ready), 32'd0);
        recv_byte(8'h12, "rd_b3");
        // queued 0x99 is only taken now, back in IDLE, and is a bad command
        chk("bp_idle_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        recv_byte(8'h3F, "queued_bad_reply");
        chk("after_queued_busy", 32'(busy), 32'd0);

        // bad command, then a normal read
        send_byte(8'h41);
        recv_byte(8'h3F, "bad_reply");
        chk("bad_idle", 32'(busy), 32'd0);
        send_frame(8'h52, 32'h0000_FFFD, 32'h0);
        chk("rd2_addr", addr, 32'h0000_FFFD);
        chk("rd2_ready", 32'(rd_ready), 32'd1);
        rdata = 32'hA5A5_0001; rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        recv_byte(8'h01, "rd2_b0");
        recv_byte(8'h00, "rd2_b1");
        recv_byte(8'hA5, "rd2_b2");
        recv_byte(8'hA5, "rd2_b3");

        // write timeout: o_wr_valid high exactly TIMEOUT=8 cycles
        send_frame(8'h57, 32'h0000_0020, 32'h1122_3344);
        chk("to_data", wdata, 32'h1122_3344);
        n = 0;
        while (wr_valid && n < 20) begin n++; @(negedge clk); end
        chk("to_valid_cycles", 32'(n), 32'd8);
        recv_byte(8'h21, "to_reply");

        // ready on the terminal cycle wins
        send_frame(8'h57, 32'h0000_0024, 32'h5566_7788);
        repeat (7) @(negedge clk);
        chk("to_edge_valid", 32'(wr_valid), 32'd1);
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        recv_byte(8'h2B, "to_edge_reply");

        // reset mid-frame, then a full read with restarted byte counter
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_tx", 32'(tx_valid), 32'd0);
        send_frame(8'h52, 32'h0000_0004, 32'h0);
        chk("post_rst_addr", addr, 32'h0000_0004);
        chk("post_rst_rd_ready", 32'(rd_ready), 32'd1);
        rdata = 32'hCAFE_F00D; rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        recv_byte(8'h0D, "post_rst_b0");
        recv_byte(8'hF0, "post_rst_b1");
        recv_byte(8'hFE, "post_rst_b2");
        recv_byte(8'hCA, "post_rst_b3");
        chk("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- UART-driven debug initiator for the CPU memory bus. Parses command frames from the UART RX byte stream, issues single word reads/writes on the same valid/ready bus that core drives, and returns status/data bytes to the UART TX stream.
- Sits between uartwriter and memmap, in parallel with core, for loading and inspecting memory without CPU software.
- Bus arbitration is outside this block; o_busy marks frames in progress.

Parameters:
DATA_WIDTH, 32, bus data width; fixed at 32 (4 payload bytes).
TIMEOUT, 1024, max cycles waiting for bus ready/valid before abort; must be >= 1.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  received byte available
o_rx_ready  out  1  byte consumed this cycle when high with i_rx_valid
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  UART TX accepts byte
o_addr  out  32  bus address
o_data  out  DATA_WIDTH  bus write data
o_wr_valid  out  1  write request
i_wr_ready  in  1  write accepted
o_wr_width  out  3  write width; constant 3'd4 (bytes) while o_wr_valid
i_data  in  DATA_WIDTH  bus read data
i_rd_valid  in  1  read data valid
o_rd_ready  out  1  read request / ready for data
o_busy  out  1  high in every state except IDLE

Behaviour:
- Handshake rule on all three interfaces: transfer occurs on a rising edge where valid && ready; valid, once raised, holds with stable data until the transfer.
- Frame formats, all multi-byte fields little-endian:
  - Write: 0x57 'W', A0..A3, D0..D3 -> reply 0x2B '+'.
  - Read: 0x52 'R', A0..A3 -> reply D0..D3.
  - Any other command byte -> reply 0x3F '?', nothing else consumed.
  - Bus timeout -> reply 0x21 '!'.
- Reset values: o_rx_ready=0, o_tx_valid=0, o_tx_data=0, o_addr=0, o_data=0, o_wr_valid=0, o_wr_width=0, o_rd_ready=0, o_busy=0. Internal state=IDLE, byte counter=0, timeout counter=0.
- States:
  - IDLE: o_rx_ready=1. On byte 'W' or 'R', latch the command and go to ADDR. Otherwise load 0x3F and go to RESP.
  - ADDR: o_rx_ready=1. Each byte shifts into o_addr[8*cnt +: 8]; cnt increments mod 4. On the 4th byte, go to DATA ('W') or BUS_RD ('R').
  - DATA: same scheme into o_data. On the 4th byte, go to BUS_WR.
  - BUS_WR:
    - o_wr_valid=1 and o_wr_width=4; o_rx_ready=0.
    - On i_wr_ready, load 0x2B and go to RESP.
    - The timeout counter increments each cycle without ready; on reaching TIMEOUT, drop o_wr_valid, load 0x21 and go to RESP.
  - BUS_RD:
    - o_rd_ready=1.
    - On i_rd_valid, latch i_data into the response shift register, set tx count=4 and go to RESP.
    - Timeout as in BUS_WR.
  - RESP:
    - o_tx_valid=1. On i_tx_ready, shift the next byte (read data low byte first) and decrement tx count; after the last byte, return to IDLE.
    - Single-byte replies have tx count=1.
- Command latency: o_wr_valid/o_rd_ready rise in the cycle after the final address/data byte transfer.
- Counters:
  - Timeout counter clears on every entry to BUS_WR/BUS_RD and never wraps.
  - Byte counter clears on every entry to ADDR/DATA.
- i_rx_valid outside IDLE/ADDR/DATA is not consumed (o_rx_ready=0); bytes back-pressure in the UART RX FIFO.
- o_addr/o_data hold their last values between frames. o_wr_valid and o_rd_ready are never high simultaneously.
- Simultaneous ready and timeout terminal cycle: the transfer wins, giving a normal reply.
- i_rst mid-frame: returns to IDLE next edge with all outputs at reset values; a partial frame is discarded and no reply is sent.

Test Plan:
- Write: bytes 57 10 00 00 00 EF BE AD DE -> one cycle later o_wr_valid=1, o_addr=0x00000010, o_data=0xDEADBEEF, o_wr_width=4; i_wr_ready after 3 cycles -> tx byte 0x2B, then IDLE, o_busy=0.
- Read: bytes 52 10 00 00 00; responder returns i_data=0x12345678 with i_rd_valid -> tx bytes 78 56 34 12 in order; hold i_tx_ready low 5 cycles mid-reply -> byte stable, no loss or duplication.
- Bad command: byte 0x41 -> single reply 0x3F; next frame 52 FD FF 00 00 executes normally with o_addr=0x0000FFFD.
- Timeout: write frame with i_wr_ready held 0, TIMEOUT=8 -> o_wr_valid high exactly 8 cycles, then low; tx 0x21. Variant with i_wr_ready on cycle 8 -> reply 0x2B.
- Reset mid-frame: i_rst after 57 10 00 -> all outputs 0 next cycle, no tx; following full read frame behaves normally (byte counter restarted).
- Back-pressure: i_rx_valid held high with queued bytes during BUS_RD/RESP -> o_rx_ready=0, no bytes consumed until IDLE.
